// File: rtl/replica_ctrl.sv
// Replica-chain job controller: shifts city data in, runs opt/settle/exchange
// iterations, shifts results out. Optional XCHG step: define REPLICA_CTRL_XCHG_EN.
package replica_ctrl_pkg;
  typedef enum logic [1:0] {
    NOP  = 2'd0,
    PREV = 2'd1,
    FOLW = 2'd2,
    SELF = 2'd3
  } replica_command_t;
endpackage

module replica_ctrl
  import replica_ctrl_pkg::*;
#(
  parameter int CITY_NUM    = 32,
  parameter int REPLICA_NUM = 4,
  parameter int SETTLE      = 10
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [15:0]                    iter_num,
  output logic                           busy,
  output logic                           done,
  output logic                           sft_in,
  output logic                           sft_out,
  output logic [$clog2(CITY_NUM)-1:0]    city_idx,
  output logic [$clog2(REPLICA_NUM)-1:0] replica_idx,
  output replica_command_t [1:0]         command,
  output logic                           opt_en,
  output logic                           rbank
);

  localparam int CW = $clog2(CITY_NUM);
  localparam int RW = $clog2(REPLICA_NUM);
  localparam int BW = CW + RW;
  localparam int WW = $clog2(SETTLE + 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(CITY_NUM * REPLICA_NUM - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SFTI,
    S_OPT,
    S_WAIT,
`ifdef REPLICA_CTRL_XCHG_EN
    S_XCHG,
`endif
    S_SFTO,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic [WW-1:0]          wait_q, wait_d;
  logic [15:0]            iter_q, iter_d;
  logic [15:0]            iter_num_q, iter_num_d;
  logic [15:0]            iter_inc;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   sft_in_q, sft_in_d;
  logic                   sft_out_q, sft_out_d;
  logic                   opt_en_q, opt_en_d;
  logic                   rbank_q, rbank_d;
  replica_command_t [1:0] cmd_q, cmd_d;

  // Beat counter packs {replica, city}; CITY_NUM is a power of two so the
  // low CW bits wrap exactly at the replica boundary.
  assign city_idx    = beat_q[CW-1:0];
  assign replica_idx = beat_q[BW-1:CW];
  assign busy        = busy_q;
  assign done        = done_q;
  assign sft_in      = sft_in_q;
  assign sft_out     = sft_out_q;
  assign opt_en      = opt_en_q;
  assign rbank       = rbank_q;
  assign command     = cmd_q;
  assign iter_inc    = iter_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    wait_d     = wait_q;
    iter_d     = iter_q;
    iter_num_d = iter_num_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_SFTI;
          beat_d     = '0;
          iter_d     = '0;
          iter_num_d = iter_num;
        end
      end
      S_SFTI: begin
        if (beat_q == BEAT_LAST) begin
          beat_d  = '0;
          state_d = (iter_num_q == 16'd0) ? S_SFTO : S_OPT;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      S_OPT: begin
        state_d = S_WAIT;
        wait_d  = '0;
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) begin
`ifdef REPLICA_CTRL_XCHG_EN
          state_d = S_XCHG;
`else
          iter_d  = iter_inc;
          state_d = (iter_inc == iter_num_q) ? S_SFTO : S_OPT;
`endif
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
`ifdef REPLICA_CTRL_XCHG_EN
      S_XCHG: begin
        iter_d  = iter_inc;
        state_d = (iter_inc == iter_num_q) ? S_SFTO : S_OPT;
      end
`endif
      S_SFTO: begin
        if (beat_q == BEAT_LAST) begin
          beat_d  = '0;
          state_d = S_DONE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies line
    // up with the state they describe.
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    sft_in_d  = (state_d == S_SFTI);
    sft_out_d = (state_d == S_SFTO);
    opt_en_d  = (state_d == S_OPT);
    cmd_d[0]  = NOP;
    cmd_d[1]  = NOP;
    if ((state_d == S_SFTI || state_d == S_SFTO) && beat_d[CW-1:0] == '0) begin
      cmd_d[0] = PREV;
      cmd_d[1] = PREV;
    end else if (state_d == S_OPT) begin
      cmd_d[0] = SELF;
      cmd_d[1] = SELF;
    end
`ifdef REPLICA_CTRL_XCHG_EN
    else if (state_d == S_XCHG) begin
      cmd_d[1] = iter_q[0] ? PREV : FOLW;
      cmd_d[0] = iter_q[0] ? FOLW : PREV;
    end
`endif
    rbank_d = rbank_q ^ ((cmd_q[0] != NOP) || (cmd_q[1] != NOP));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      wait_q     <= '0;
      iter_q     <= '0;
      iter_num_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sft_in_q   <= 1'b0;
      sft_out_q  <= 1'b0;
      opt_en_q   <= 1'b0;
      rbank_q    <= 1'b0;
      cmd_q[0]   <= NOP;
      cmd_q[1]   <= NOP;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      wait_q     <= wait_d;
      iter_q     <= iter_d;
      iter_num_q <= iter_num_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sft_in_q   <= sft_in_d;
      sft_out_q  <= sft_out_d;
      opt_en_q   <= opt_en_d;
      rbank_q    <= rbank_d;
      cmd_q      <= cmd_d;
    end
  end

endmodule
